cru_arbiter: RTL and testbench

- Shares one cru_shared twiddle-multiply unit between NREQ requesters, e.g. the FFT engine and the bispectrum/PSD post-processing datapath.
- Arbitration is round-robin with grant locking, so the CRU-side request stays stable while stalled.
- Request order is recorded in a tag FIFO, and each CRU response is routed back to its originator in order.
- The CRU-side interface matches the cru_shared req/resp valid-ready ports, so the arbiter sits directly in front of it.

---
 rtl/cru_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_cru_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cru_arbiter.sv
// -----------------------------------------------------------------------------
// cru_arbiter
//
// Shares a single cru_shared twiddle-multiply unit between NREQ requesters.
// Requests are arbitrated round-robin; once a granted request stalls on
// cru_req_ready the grant is locked so the CRU-side request stays stable.
// Every accepted request pushes its requester index into a tag FIFO. CRU
// responses come back in order and are routed to the requester at the FIFO
// head. Both paths are zero-cycle (purely combinational through the arbiter).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   m_req_valid/ready        per-requester request handshake
//   m_xr, m_xi, m_angle_idx  packed per-requester operands (requester i at
//                            [i*W +: W])
//   m_resp_valid/ready       per-requester response handshake (valid one-hot)
//   m_yr, m_yi               response data, broadcast to all requesters
//   cru_req_*                request channel towards cru_shared
//   cru_resp_*, cru_yr/yi    response channel from cru_shared
//   outstanding              number of CRU transactions in flight
//   err_orphan               sticky: a response arrived with no tag pending
// -----------------------------------------------------------------------------
module cru_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ANGLE_W = 9,
  parameter int NREQ    = 2,
  parameter int MAX_OUT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          m_req_valid,
  output logic [NREQ-1:0]          m_req_ready,
  input  logic [NREQ*DATA_W-1:0]   m_xr,
  input  logic [NREQ*DATA_W-1:0]   m_xi,
  input  logic [NREQ*ANGLE_W-1:0]  m_angle_idx,
  output logic [NREQ-1:0]          m_resp_valid,
  input  logic [NREQ-1:0]          m_resp_ready,
  output logic [DATA_W-1:0]        m_yr,
  output logic [DATA_W-1:0]        m_yi,
  output logic                     cru_req_valid,
  input  logic                     cru_req_ready,
  output logic [DATA_W-1:0]        cru_xr,
  output logic [DATA_W-1:0]        cru_xi,
  output logic [ANGLE_W-1:0]       cru_angle_idx,
  input  logic                     cru_resp_valid,
  output logic                     cru_resp_ready,
  input  logic [DATA_W-1:0]        cru_yr,
  input  logic [DATA_W-1:0]        cru_yi,
  output logic [$clog2(MAX_OUT):0] outstanding,
  output logic                     err_orphan
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  // Arbitration state
  logic [IDX_W-1:0] r_rr_ptr;
  logic             r_lock;
  logic [IDX_W-1:0] r_gsel;

  // Tag FIFO state
  logic [IDX_W-1:0] r_tag_mem [MAX_OUT];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_err_orphan;

  // Per-requester operand views
  logic [DATA_W-1:0]  w_xr_arr  [NREQ];
  logic [DATA_W-1:0]  w_xi_arr  [NREQ];
  logic [ANGLE_W-1:0] w_ang_arr [NREQ];

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IDX_W-1:0]  w_off;
  logic [IDX_W:0]    w_sum;
  logic [IDX_W-1:0]  w_rr_grant;
  logic [IDX_W-1:0]  w_grant;
  logic [IDX_W-1:0]  w_grant_inc;
  logic              w_full;
  logic              w_empty;
  logic              w_req_valid;
  logic              w_accept;
  logic              w_pop;
  logic              w_orphan;
  logic [IDX_W-1:0]  w_head;
  logic [PTR_W-1:0]  w_wr_ptr_inc;
  logic [PTR_W-1:0]  w_rd_ptr_inc;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_xr_arr[gi]  = m_xr[gi*DATA_W +: DATA_W];
      assign w_xi_arr[gi]  = m_xi[gi*DATA_W +: DATA_W];
      assign w_ang_arr[gi] = m_angle_idx[gi*ANGLE_W +: ANGLE_W];
    end
  endgenerate

  // Round-robin search: rotate the valid vector so that bit 0 corresponds to
  // r_rr_ptr, find the lowest set bit, then add the offset back mod NREQ.
  assign w_dbl = {m_req_valid, m_req_valid};
  assign w_rot = w_dbl[NREQ-1:0] >> r_rr_ptr | w_dbl[2*NREQ-1:NREQ] << (IDX_W'(NREQ) - r_rr_ptr);

  always_comb begin
    w_off = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_off = IDX_W'(j);
      end
    end
  end

  assign w_sum      = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_rr_grant = (w_sum >= (IDX_W+1)'(NREQ)) ? IDX_W'(w_sum - (IDX_W+1)'(NREQ))
                                                  : IDX_W'(w_sum);

  // A locked grant is held until the CRU accepts it.
  assign w_grant     = r_lock ? r_gsel : w_rr_grant;
  assign w_grant_inc = (w_grant == IDX_W'(NREQ - 1)) ? '0 : w_grant + 1'b1;

  // The full check uses the registered count: a pop in the same cycle does
  // not open a slot until the next cycle.
  assign w_full      = (r_count == CNT_W'(MAX_OUT));
  assign w_empty     = (r_count == '0);
  assign w_req_valid = !rst && !w_full && (r_lock || (|m_req_valid));
  assign w_accept    = w_req_valid && cru_req_ready;

  assign cru_req_valid = w_req_valid;
  assign cru_xr        = w_xr_arr[w_grant];
  assign cru_xi        = w_xi_arr[w_grant];
  assign cru_angle_idx = w_ang_arr[w_grant];

  // Response routing follows the oldest outstanding tag.
  assign w_head   = r_tag_mem[r_rd_ptr];
  assign w_pop    = !w_empty && cru_resp_valid && m_resp_ready[w_head];
  // With no tag pending the response is swallowed and flagged.
  assign w_orphan = !rst && w_empty && cru_resp_valid;

  assign cru_resp_ready = !rst && (w_empty || m_resp_ready[w_head]);
  assign m_yr           = cru_yr;
  assign m_yi           = cru_yi;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_route
      assign m_req_ready[gi]  = w_accept && (w_grant == IDX_W'(gi));
      assign m_resp_valid[gi] = !rst && !w_empty && cru_resp_valid &&
                                (w_head == IDX_W'(gi));
    end
  endgenerate

  assign w_wr_ptr_inc = (r_wr_ptr == PTR_W'(MAX_OUT - 1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_inc = (r_rd_ptr == PTR_W'(MAX_OUT - 1)) ? '0 : r_rd_ptr + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_lock       <= 1'b0;
      r_gsel       <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_accept) begin
        r_lock   <= 1'b0;
        r_rr_ptr <= w_grant_inc;
        r_wr_ptr <= w_wr_ptr_inc;
      end else if (w_req_valid) begin
        // Stalled: freeze the grant so the CRU sees a stable request.
        r_lock <= 1'b1;
        r_gsel <= w_grant;
      end

      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end

      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_orphan) begin
        r_err_orphan <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset; only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tag_mem[r_wr_ptr] <= w_grant;
    end
  end

  assign outstanding = r_count;
  assign err_orphan  = r_err_orphan;

endmodule

// File: tb/tb_cru_arbiter.sv
module tb_cru_arbiter;

  localparam int DW      = 16;
  localparam int AW      = 9;
  localparam int NREQ    = 2;
  localparam int MAX_OUT = 4;
  localparam int CW      = $clog2(MAX_OUT) + 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     m_req_valid;
  logic [NREQ-1:0]     m_req_ready;
  logic [NREQ*DW-1:0]  m_xr;
  logic [NREQ*DW-1:0]  m_xi;
  logic [NREQ*AW-1:0]  m_angle_idx;
  logic [NREQ-1:0]     m_resp_valid;
  logic [NREQ-1:0]     m_resp_ready;
  logic [DW-1:0]       m_yr;
  logic [DW-1:0]       m_yi;
  logic                cru_req_valid;
  logic                cru_req_ready;
  logic [DW-1:0]       cru_xr;
  logic [DW-1:0]       cru_xi;
  logic [AW-1:0]       cru_angle_idx;
  logic                cru_resp_valid;
  logic                cru_resp_ready;
  logic [DW-1:0]       cru_yr;
  logic [DW-1:0]       cru_yi;
  logic [CW-1:0]       outstanding;
  logic                err_orphan;

  always #5 clk = ~clk;

  cru_arbiter #(.DATA_W(DW), .ANGLE_W(AW), .NREQ(NREQ), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_xr(m_xr), .m_xi(m_xi), .m_angle_idx(m_angle_idx),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
    .m_yr(m_yr), .m_yi(m_yi),
    .cru_req_valid(cru_req_valid), .cru_req_ready(cru_req_ready),
    .cru_xr(cru_xr), .cru_xi(cru_xi), .cru_angle_idx(cru_angle_idx),
    .cru_resp_valid(cru_resp_valid), .cru_resp_ready(cru_resp_ready),
    .cru_yr(cru_yr), .cru_yi(cru_yi),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  typedef struct { int id; logic [DW-1:0] yr; logic [DW-1:0] yi; } exp_t;
  typedef struct { logic [DW-1:0] yr; logic [DW-1:0] yi; } res_t;

  // Reference model: order of issued requesters, CRU pipeline contents,
  // and per-requester expected results.
  int   tags[$];
  res_t pipe[$];
  exp_t expq[$];
  int   rr;
  int   hold;
  bit   locked;
  bit   orphan_m;

  bit            pend_v   [NREQ];
  logic [DW-1:0] pend_xr  [NREQ];
  logic [DW-1:0] pend_xi  [NREQ];
  logic [AW-1:0] pend_ang [NREQ];

  int p_new, rdy_pct, resp_pct, rrdy_pct;
  bit auto_gen, orphan_pulse;

  logic [NREQ-1:0] last_mready;
  logic [NREQ-1:0] last_mresp;
  logic            last_crr;
  logic [DW-1:0]   last_xr;
  int              dut_resp_cnt [NREQ];

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t cru_fn(input logic [DW-1:0] xr, input logic [DW-1:0] xi,
                                  input logic [AW-1:0] a);
    res_t r;
    r.yr = xr + DW'(a);
    r.yi = xi ^ DW'(a);
    return r;
  endfunction

  function automatic bit pend_any();
    bit b = 0;
    for (int i = 0; i < NREQ; i++) b = b | pend_v[i];
    return b;
  endfunction

  task automatic cycle();
    int g, h, k, found;
    bit full, e_rv, acc, pop, orph, e_crr;
    logic [NREQ-1:0] e_mr, e_resp;
    res_t r;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (auto_gen && !pend_v[i] && int'($urandom_range(99)) < p_new) begin
        pend_v[i]   = 1;
        pend_xr[i]  = DW'($urandom);
        pend_xi[i]  = DW'($urandom);
        pend_ang[i] = AW'($urandom);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      m_req_valid[i]          = pend_v[i];
      m_xr[i*DW +: DW]        = pend_xr[i];
      m_xi[i*DW +: DW]        = pend_xi[i];
      m_angle_idx[i*AW +: AW] = pend_ang[i];
      m_resp_ready[i]         = (int'($urandom_range(99)) < rrdy_pct);
    end
    cru_req_ready = (int'($urandom_range(99)) < rdy_pct);
    if (orphan_pulse) begin
      cru_resp_valid = 1'b1;
      cru_yr = DW'($urandom);
      cru_yi = DW'($urandom);
    end else if (pipe.size() > 0 && int'($urandom_range(99)) < resp_pct) begin
      cru_resp_valid = 1'b1;
      cru_yr = pipe[0].yr;
      cru_yi = pipe[0].yi;
    end else begin
      cru_resp_valid = 1'b0;
      cru_yr = DW'($urandom);
      cru_yi = DW'($urandom);
    end
    #1;
    full = (tags.size() == MAX_OUT);
    if (locked) g = hold;
    else begin
      g = -1;
      for (int j = 0; j < NREQ; j++)
        if (g < 0 && pend_v[(rr + j) % NREQ]) g = (rr + j) % NREQ;
    end
    e_rv = !full && (locked || g >= 0);
    acc  = e_rv && cru_req_ready;
    e_mr = acc ? NREQ'(1 << g) : '0;
    chk("cru_req_valid", cru_req_valid, e_rv);
    chk("m_req_ready", m_req_ready, e_mr);
    if (e_rv) begin
      chk("cru_xr", cru_xr, pend_xr[g]);
      chk("cru_xi", cru_xi, pend_xi[g]);
      chk("cru_angle_idx", cru_angle_idx, pend_ang[g]);
    end
    if (tags.size() > 0) begin
      h      = tags[0];
      e_resp = cru_resp_valid ? NREQ'(1 << h) : '0;
      e_crr  = m_resp_ready[h];
      pop    = cru_resp_valid && m_resp_ready[h];
      orph   = 0;
    end else begin
      h      = -1;
      e_resp = '0;
      e_crr  = 1;
      pop    = 0;
      orph   = cru_resp_valid;
    end
    chk("m_resp_valid", m_resp_valid, e_resp);
    chk("cru_resp_ready", cru_resp_ready, e_crr);
    chk("outstanding", outstanding, tags.size());
    chk("err_orphan", err_orphan, orphan_m);
    if (pop) begin
      found = -1;
      for (k = 0; k < expq.size(); k++)
        if (found < 0 && expq[k].id == h) found = k;
      chk("resp_owner_found", found >= 0, 1);
      if (found >= 0) begin
        chk("m_yr", m_yr, expq[found].yr);
        chk("m_yi", m_yi, expq[found].yi);
        expq.delete(found);
      end
    end
    last_mready = m_req_ready;
    last_mresp  = m_resp_valid;
    last_crr    = cru_resp_ready;
    last_xr     = cru_xr;
    for (int i = 0; i < NREQ; i++)
      if (m_resp_valid[i] && m_resp_ready[i]) dut_resp_cnt[i]++;
    @(posedge clk);
    if (pop) begin
      void'(tags.pop_front());
      void'(pipe.pop_front());
    end
    if (orph) orphan_m = 1;
    if (acc) begin
      tags.push_back(g);
      r = cru_fn(pend_xr[g], pend_xi[g], pend_ang[g]);
      pipe.push_back(r);
      expq.push_back('{g, r.yr, r.yi});
      pend_v[g] = 0;
      rr        = (g + 1) % NREQ;
      locked    = 0;
    end else if (e_rv) begin
      locked = 1;
      hold   = g;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    m_req_valid    = '1;
    cru_req_ready  = 1'b1;
    cru_resp_valid = 1'b1;
    m_resp_ready   = '1;
    #1;
    chk("rst_cru_req_valid", cru_req_valid, 0);
    chk("rst_m_req_ready", m_req_ready, 0);
    chk("rst_m_resp_valid", m_resp_valid, 0);
    chk("rst_cru_resp_ready", cru_resp_ready, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err_orphan", err_orphan, 0);
    @(posedge clk);
    @(negedge clk);
    rst            = 1'b0;
    m_req_valid    = '0;
    cru_resp_valid = 1'b0;
    tags.delete();
    pipe.delete();
    expq.delete();
    rr = 0; locked = 0; hold = 0; orphan_m = 0;
    for (int i = 0; i < NREQ; i++) pend_v[i] = 0;
  endtask

  task automatic drain();
    auto_gen = 0; rdy_pct = 100; resp_pct = 100; rrdy_pct = 100;
    for (int n = 0; n < 100 && (pend_any() || tags.size() > 0); n++) cycle();
    #1;
    chk("drain_outstanding", outstanding, 0);
  endtask

  initial begin
    int acc_cnt, prev, id;
    checks = 0; errors = 0;
    rst = 1'b1; m_req_valid = '0; m_xr = '0; m_xi = '0; m_angle_idx = '0;
    m_resp_ready = '0; cru_req_ready = 1'b0; cru_resp_valid = 1'b0;
    cru_yr = '0; cru_yi = '0;
    auto_gen = 0; orphan_pulse = 0; p_new = 0;
    rdy_pct = 100; resp_pct = 100; rrdy_pct = 100;
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i] = 0; pend_xr[i] = '0; pend_xi[i] = '0; pend_ang[i] = '0;
      dut_resp_cnt[i] = 0;
    end
    do_reset();

    // Single requester, angles 0..2, immediate acceptance
    for (int a = 0; a < 3; a++) begin
      pend_v[0] = 1; pend_xr[0] = 16'h4000; pend_xi[0] = '0; pend_ang[0] = AW'(a);
      cycle();
      chk("t1_same_cycle_accept", last_mready, 1);
    end
    for (int n = 0; n < 6; n++) cycle();
    chk("t1_resp_count", dut_resp_cnt[0], 3);
    chk("t1_no_orphan", err_orphan, 0);

    // Both requesters continuously valid: grants alternate
    auto_gen = 1; p_new = 100;
    prev = -1;
    for (int n = 0; n < 12; n++) begin
      cycle();
      if (last_mready != '0) begin
        id = last_mready[1] ? 1 : 0;
        if (prev >= 0) chk("t2_alternate", id, 1 - prev);
        prev = id;
      end
    end
    drain();

    // Stall locks the grant on requester 0
    rdy_pct = 0;
    pend_v[0] = 1; pend_xr[0] = 16'h1234; pend_xi[0] = 16'h0011; pend_ang[0] = 9'h05;
    cycle();
    pend_v[1] = 1; pend_xr[1] = 16'h5678; pend_xi[1] = 16'h0022; pend_ang[1] = 9'h0a;
    for (int n = 0; n < 3; n++) begin
      cycle();
      chk("t3_hold_xr", last_xr, 16'h1234);
    end
    rdy_pct = 100;
    cycle();
    chk("t3_accept_req0", last_mready, 1);
    cycle();
    chk("t3_accept_req1", last_mready, 2);
    drain();

    // Fill to MAX_OUT with responses withheld
    resp_pct = 0; auto_gen = 1; p_new = 100; rdy_pct = 100; rrdy_pct = 100;
    acc_cnt = 0;
    for (int n = 0; n < 8; n++) begin
      cycle();
      if (last_mready != '0) acc_cnt++;
    end
    chk("t4_accepts", acc_cnt, MAX_OUT);
    #1;
    chk("t4_outstanding_full", outstanding, MAX_OUT);
    chk("t4_req_valid_full", cru_req_valid, 0);
    resp_pct = 100;
    cycle();
    chk("t4_no_accept_while_full", last_mready, 0);
    #1;
    chk("t4_after_pop", outstanding, MAX_OUT - 1);
    cycle();
    chk("t4_push_with_pop", |last_mready, 1);
    #1;
    chk("t4_push_pop_same", outstanding, MAX_OUT - 1);
    resp_pct = 0;
    cycle();
    #1;
    chk("t4_refill", outstanding, MAX_OUT);
    drain();

    // Orphan response
    orphan_pulse = 1;
    cycle();
    orphan_pulse = 0;
    chk("t5_resp_ready", last_crr, 1);
    chk("t5_no_resp_valid", last_mresp, 0);
    #1;
    chk("t5_orphan_set", err_orphan, 1);
    for (int n = 0; n < 3; n++) cycle();
    #1;
    chk("t5_orphan_sticky", err_orphan, 1);

    // Reset with transactions in flight
    auto_gen = 1; p_new = 100; resp_pct = 0; rdy_pct = 100;
    for (int n = 0; n < 10 && tags.size() < 2; n++) cycle();
    #1;
    chk("t6_two_outstanding", outstanding, 2);
    do_reset();
    auto_gen = 0;
    pend_v[0] = 1; pend_xr[0] = 16'h0abc; pend_xi[0] = 16'h0001; pend_ang[0] = 9'h011;
    pend_v[1] = 1; pend_xr[1] = 16'h0def; pend_xi[1] = 16'h0002; pend_ang[1] = 9'h022;
    cycle();
    chk("t6_lowest_after_reset", last_mready, 1);
    drain();

    // Randomized traffic
    for (int blk = 0; blk < 15; blk++) begin
      p_new    = int'($urandom_range(100, 10));
      rdy_pct  = int'($urandom_range(100, 0));
      resp_pct = int'($urandom_range(100, 0));
      rrdy_pct = int'($urandom_range(100, 20));
      auto_gen = 1;
      for (int n = 0; n < 200; n++) cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
